store_unit: RTL

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/ariane_pkg.sv | 34 +++
 rtl/store_data_align.sv | 29 ++
 rtl/store_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared store-path types: access size encoding, store FSM states and a misalignment helper.
package ariane_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    TRANSLATE = 2'b01,
    WAIT_SB   = 2'b10
  } store_state_e;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned BE_LEN = XLEN / 8;

  // A natural-alignment violation: any address bit below the access size is set.
  function automatic logic is_misaligned(input size_e size, input logic [2:0] offset);
    logic bad;
    bad = 1'b0;
    unique case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = offset[0];
      SIZE_W:  bad = |offset[1:0];
      SIZE_D:  bad = |offset;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_data_align.sv
// Combinational byte-lane placement of store data and byte enables within a 64-bit word.
module store_data_align
  import ariane_pkg::*;
(
  input  logic [2:0]        offset,
  input  size_e             size,
  input  logic [XLEN-1:0]   data_in,
  output logic [BE_LEN-1:0] be,
  output logic [XLEN-1:0]   data_out
);

  logic [BE_LEN-1:0] be_base;

  always_comb begin
    be_base = 8'h01;
    unique case (size)
      SIZE_B:  be_base = 8'h01;
      SIZE_H:  be_base = 8'h03;
      SIZE_W:  be_base = 8'h0F;
      SIZE_D:  be_base = 8'hFF;
      default: be_base = 8'h01;
    endcase
  end

  // Lanes pushed past byte 7 are dropped; the store buffer only sees this word.
  assign be       = be_base << offset;
  assign data_out = data_in << {offset, 3'b000};

endmodule

// File: rtl/store_unit.sv
// Store unit: capture, translate via MMU, push to store buffer, report writeback.
// Optional macro STORE_MISALIGN_CHECK_EN raises a misalignment exception instead of translating.
module store_unit
  import ariane_pkg::*;
#(
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [63:0]              vaddr_i,
  input  logic [63:0]              data_i,
  input  logic [1:0]               size_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     translation_req_o,
  output logic [63:0]              vaddr_o,
  input  logic                     translation_valid_i,
  input  logic [63:0]              paddr_i,
  input  logic                     xlate_ex_i,
  output logic                     sb_valid_o,
  output logic                     sb_valid_without_flush_o,
  input  logic                     sb_ready_i,
  output logic [63:0]              sb_paddr_o,
  output logic [63:0]              sb_data_o,
  output logic [7:0]               sb_be_o,
  output logic [1:0]               sb_size_o,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     ex_valid_o,
  output logic [63:0]              ex_tval_o
);

  store_state_e state_q, state_d;

  logic [63:0]              vaddr_q, vaddr_d;
  logic [63:0]              paddr_q, paddr_d;
  logic [63:0]              data_q, data_d;
  logic [7:0]               be_q, be_d;
  size_e                    size_q, size_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;

  logic                     valid_d;
  logic                     ex_valid_d;
  logic [63:0]              res_tval_d;
  logic [TRANS_ID_BITS-1:0] res_tid_d;

  size_e       size_in;
  logic [7:0]  be_aligned;
  logic [63:0] data_aligned;
  logic        misaligned;

  assign size_in = size_e'(size_i);

  store_data_align u_align (
    .offset   (vaddr_i[2:0]),
    .size     (size_in),
    .data_in  (data_i),
    .be       (be_aligned),
    .data_out (data_aligned)
  );

`ifdef STORE_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(size_in, vaddr_i[2:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d                  = state_q;
    vaddr_d                  = vaddr_q;
    paddr_d                  = paddr_q;
    data_d                   = data_q;
    be_d                     = be_q;
    size_d                   = size_q;
    tid_d                    = tid_q;
    valid_d                  = 1'b0;
    ex_valid_d               = 1'b0;
    res_tval_d               = 64'd0;
    res_tid_d                = tid_q;
    ready_o                  = 1'b0;
    translation_req_o        = 1'b0;
    sb_valid_o               = 1'b0;
    sb_valid_without_flush_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !flush_i) begin
          vaddr_d = vaddr_i;
          data_d  = data_aligned;
          be_d    = be_aligned;
          size_d  = size_in;
          tid_d   = trans_id_i;
          if (misaligned) begin
            // Exception reported straight from issue; the unit stays free.
            valid_d    = 1'b1;
            ex_valid_d = 1'b1;
            res_tval_d = vaddr_i;
            res_tid_d  = trans_id_i;
          end else begin
            state_d = TRANSLATE;
          end
        end
      end

      TRANSLATE: begin
        translation_req_o = 1'b1;
        if (translation_valid_i) begin
          if (xlate_ex_i) begin
            valid_d    = 1'b1;
            ex_valid_d = 1'b1;
            res_tval_d = vaddr_q;
            res_tid_d  = tid_q;
            state_d    = IDLE;
          end else begin
            paddr_d = paddr_i;
            state_d = WAIT_SB;
          end
        end
      end

      WAIT_SB: begin
        sb_valid_without_flush_o = sb_ready_i;
        sb_valid_o               = sb_ready_i && !flush_i;
        if (sb_ready_i && !flush_i) begin
          valid_d   = 1'b1;
          res_tid_d = tid_q;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A flush wins over every handshake: nothing from the killed store may retire.
    if (flush_i) begin
      state_d    = IDLE;
      valid_d    = 1'b0;
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      vaddr_q    <= 64'd0;
      paddr_q    <= 64'd0;
      data_q     <= 64'd0;
      be_q       <= 8'd0;
      size_q     <= SIZE_B;
      tid_q      <= '0;
      valid_o    <= 1'b0;
      ex_valid_o <= 1'b0;
      ex_tval_o  <= 64'd0;
      trans_id_o <= '0;
    end else begin
      state_q    <= state_d;
      vaddr_q    <= vaddr_d;
      paddr_q    <= paddr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      size_q     <= size_d;
      tid_q      <= tid_d;
      valid_o    <= valid_d;
      ex_valid_o <= ex_valid_d;
      if (valid_d) begin
        ex_tval_o  <= res_tval_d;
        trans_id_o <= res_tid_d;
      end
    end
  end

  assign vaddr_o    = vaddr_q;
  assign sb_paddr_o = paddr_q;
  assign sb_data_o  = data_q;
  assign sb_be_o    = be_q;
  assign sb_size_o  = size_q;

endmodule
